// File: rtl/ctrl_pkg.sv
// Shared constants and types for the control decode pipeline:
// opcodes, ALU control codes, FSM states and the output bundle.
package ctrl_pkg;

   localparam logic [6:0] OPC_R = 7'b0110011;
   localparam logic [6:0] OPC_I = 7'b0010011;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_SRL = 4'b0101;
   localparam logic [3:0] ALU_MUL = 4'b0110;
   localparam logic [3:0] ALU_XOR = 4'b0111;
   localparam logic [3:0] ALU_HCF = 4'b1001;
   localparam logic [3:0] ALU_ILL = 4'b1111;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MULWAIT = 2'd1,
      HALT    = 2'd2
   } state_e;

   typedef struct packed {
      logic [3:0]  alu;
      logic        regwrite;
      logic        use_imm;
      logic        illegal;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [11:0] imm;
   } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: R-type and optional I-type ALU ops
// into ALU control, write enable, immediate select and register fields.
module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter int ENABLE_ITYPE = 1
) (
   input  logic [31:0] instr_i,
   output logic [3:0]  alu_o,
   output logic        regwrite_o,
   output logic        use_imm_o,
   output logic        illegal_o,
   output logic [11:0] imm_o,
   output logic [4:0]  rd_o,
   output logic [4:0]  rs1_o,
   output logic [4:0]  rs2_o
);

   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;
   logic       bad;

   assign opc   = instr_i[6:0];
   assign f3    = instr_i[14:12];
   assign f7    = instr_i[31:25];
   assign rd_o  = instr_i[11:7];
   assign rs1_o = instr_i[19:15];
   assign rs2_o = instr_i[24:20];

   always_comb begin
      alu_o      = ALU_AND;
      regwrite_o = 1'b0;
      use_imm_o  = 1'b0;
      illegal_o  = 1'b0;
      imm_o      = '0;
      bad        = 1'b0;
      if (opc == OPC_R) begin
         regwrite_o = 1'b1;
         if (f7 == 7'h00) begin
            case (f3)
               3'd0:    alu_o = ALU_ADD;
               3'd6:    alu_o = ALU_OR;
               3'd7:    alu_o = ALU_AND;
               3'd1:    alu_o = ALU_SLL;
               3'd5:    alu_o = ALU_SRL;
               3'd2:    alu_o = ALU_MUL;
               3'd4:    alu_o = ALU_XOR;
               default: bad   = 1'b1;
            endcase
         end else if (f7 == 7'h01 && f3 == 3'd0) begin
            alu_o      = ALU_HCF;
            regwrite_o = 1'b0;
         end else begin
            bad = 1'b1;
         end
      end else if (opc == OPC_I && ENABLE_ITYPE != 0) begin
         regwrite_o = 1'b1;
         use_imm_o  = 1'b1;
         imm_o      = instr_i[31:20];
         case (f3)
            3'd0:    alu_o = ALU_ADD;
            3'd6:    alu_o = ALU_OR;
            3'd7:    alu_o = ALU_AND;
            3'd4:    alu_o = ALU_XOR;
            3'd1:    if (f7 == 7'h00) alu_o = ALU_SLL; else bad = 1'b1;
            3'd5:    if (f7 == 7'h00) alu_o = ALU_SRL; else bad = 1'b1;
            default: bad = 1'b1;
         endcase
      end
      if (bad) begin
         alu_o      = ALU_ILL;
         regwrite_o = 1'b0;
         illegal_o  = 1'b1;
      end
   end

endmodule

// File: rtl/control_pipe.sv
// One-deep decode pipeline with valid/ready on both sides, a MUL
// multi-cycle stall and a halt-and-catch-fire state left via resume.
module control_pipe
   import ctrl_pkg::*;
#(
   parameter int ENABLE_ITYPE = 1,
   parameter int MUL_STALL    = 2,
   parameter int ACW          = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [31:0]    instr,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [ACW-1:0] alu_control,
   output logic           regwrite,
   output logic           use_imm,
   output logic           illegal,
   output logic [4:0]     rd,
   output logic [4:0]     rs1,
   output logic [4:0]     rs2,
   output logic [11:0]    imm,
   input  logic           resume,
   output logic           halted
);

   localparam logic [3:0] STALL = 4'(MUL_STALL);

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       vld_q, vld_d;
   ctrl_t      bndl_q, bndl_d;
   ctrl_t      dec;

   logic accept;
   logic take;
   logic is_mul;
   logic is_hcf;
   logic mul_wait;

   ctrl_decode #(
      .ENABLE_ITYPE (ENABLE_ITYPE)
   ) u_dec (
      .instr_i    (instr),
      .alu_o      (dec.alu),
      .regwrite_o (dec.regwrite),
      .use_imm_o  (dec.use_imm),
      .illegal_o  (dec.illegal),
      .imm_o      (dec.imm),
      .rd_o       (dec.rd),
      .rs1_o      (dec.rs1),
      .rs2_o      (dec.rs2)
   );

   assign accept   = in_valid && in_ready;
   assign take     = vld_q && out_ready;
   assign is_mul   = dec.alu == ALU_MUL && !dec.illegal;
   assign is_hcf   = dec.alu == ALU_HCF && !dec.illegal;
   assign mul_wait = is_mul && STALL != 4'd0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= RUN;
         cnt_q   <= '0;
         vld_q   <= 1'b0;
         bndl_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         vld_q   <= vld_d;
         bndl_q  <= bndl_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      vld_d   = vld_q && !take;
      bndl_d  = bndl_q;
      case (state_q)
         RUN: begin
            if (accept) begin
               bndl_d = dec;
               vld_d  = !mul_wait;
               if (is_hcf) begin
                  state_d = HALT;
               end else if (mul_wait) begin
                  state_d = MULWAIT;
                  cnt_d   = STALL;
               end
            end
         end
         MULWAIT: begin
            // Bundle is already captured; it becomes visible as cnt hits 0
            if (cnt_q <= 4'd1) begin
               cnt_d   = '0;
               vld_d   = 1'b1;
               state_d = RUN;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         HALT: begin
            if (resume) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      in_ready  = rst_n && state_q == RUN && (!vld_q || out_ready);
      halted    = state_q == HALT;
      out_valid = vld_q;
      regwrite  = bndl_q.regwrite;
      use_imm   = bndl_q.use_imm;
      illegal   = bndl_q.illegal;
      rd        = bndl_q.rd;
      rs1       = bndl_q.rs1;
      rs2       = bndl_q.rs2;
      imm       = bndl_q.imm;
      alu_control      = '0;
      alu_control[3:0] = bndl_q.alu;
      if (bndl_q.illegal) alu_control = '1;
   end

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe: decode table, MUL stall, HCF halt,
// backpressure, reset behaviour, plus an ITYPE-off / zero-stall instance.
module tb_control_pipe;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  alu_control;
   logic        regwrite;
   logic        use_imm;
   logic        illegal;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [11:0] imm;
   logic        resume;
   logic        halted;

   logic        in_valid_b;
   logic        in_ready_b;
   logic        out_valid_b;
   logic        out_ready_b;
   logic [3:0]  alu_control_b;
   logic        regwrite_b;
   logic        use_imm_b;
   logic        illegal_b;
   logic [4:0]  rd_b;
   logic [4:0]  rs1_b;
   logic [4:0]  rs2_b;
   logic [11:0] imm_b;
   logic        resume_b;
   logic        halted_b;

   int errors = 0;
   int checks = 0;

   control_pipe #(
      .ENABLE_ITYPE (1),
      .MUL_STALL    (2),
      .ACW          (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .instr       (instr),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .alu_control (alu_control),
      .regwrite    (regwrite),
      .use_imm     (use_imm),
      .illegal     (illegal),
      .rd          (rd),
      .rs1         (rs1),
      .rs2         (rs2),
      .imm         (imm),
      .resume      (resume),
      .halted      (halted)
   );

   control_pipe #(
      .ENABLE_ITYPE (0),
      .MUL_STALL    (0),
      .ACW          (4)
   ) dut_b (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid_b),
      .in_ready    (in_ready_b),
      .instr       (instr),
      .out_valid   (out_valid_b),
      .out_ready   (out_ready_b),
      .alu_control (alu_control_b),
      .regwrite    (regwrite_b),
      .use_imm     (use_imm_b),
      .illegal     (illegal_b),
      .rd          (rd_b),
      .rs1         (rs1_b),
      .rs2         (rs2_b),
      .imm         (imm_b),
      .resume      (resume_b),
      .halted      (halted_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      resume      = 1'b0;
      instr       = '0;
      in_valid_b  = 1'b0;
      out_ready_b = 1'b1;
      resume_b    = 1'b0;

      tick();
      tick();
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_halted", 32'(halted), 0);
      chk("rst_alu", 32'(alu_control), 0);
      chk("rst_rd", 32'(rd), 0);
      chk("rst_imm", 32'(imm), 0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 1);

      // ADD x3,x1,x2
      instr    = 32'h002081B3;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("add_valid", 32'(out_valid), 1);
      chk("add_alu", 32'(alu_control), 32'h2);
      chk("add_regwrite", 32'(regwrite), 1);
      chk("add_use_imm", 32'(use_imm), 0);
      chk("add_illegal", 32'(illegal), 0);
      chk("add_rd", 32'(rd), 3);
      chk("add_rs1", 32'(rs1), 1);
      chk("add_rs2", 32'(rs2), 2);
      tick();
      chk("add_drain", 32'(out_valid), 0);

      // XOR (f3=4)
      instr    = 32'h0020C1B3;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("xor_alu", 32'(alu_control), 32'h7);
      tick();

      // MUL with 2-cycle stall
      instr    = 32'h0020A1B3;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("mul_c1_ready", 32'(in_ready), 0);
      chk("mul_c1_valid", 32'(out_valid), 0);
      tick();
      chk("mul_c2_ready", 32'(in_ready), 0);
      chk("mul_c2_valid", 32'(out_valid), 0);
      tick();
      chk("mul_c3_valid", 32'(out_valid), 1);
      chk("mul_c3_alu", 32'(alu_control), 32'h6);
      chk("mul_c3_ready", 32'(in_ready), 1);
      tick();
      chk("mul_drain", 32'(out_valid), 0);

      // MUL on zero-stall instance
      in_valid_b = 1'b1;
      tick();
      in_valid_b = 1'b0;
      chk("b_mul_valid", 32'(out_valid_b), 1);
      chk("b_mul_alu", 32'(alu_control_b), 32'h6);
      tick();

      // HCF then ADD held until resume
      instr    = 32'h022081B3;
      in_valid = 1'b1;
      tick();
      instr = 32'h002081B3;
      chk("hcf_valid", 32'(out_valid), 1);
      chk("hcf_alu", 32'(alu_control), 32'h9);
      chk("hcf_regwrite", 32'(regwrite), 0);
      chk("hcf_halted", 32'(halted), 1);
      chk("hcf_in_ready", 32'(in_ready), 0);
      tick();
      chk("halt_drained", 32'(out_valid), 0);
      chk("halt_in_ready", 32'(in_ready), 0);
      tick();
      chk("halt_still", 32'(halted), 1);
      resume = 1'b1;
      tick();
      resume = 1'b0;
      chk("resume_halted", 32'(halted), 0);
      chk("resume_in_ready", 32'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      chk("after_hcf_valid", 32'(out_valid), 1);
      chk("after_hcf_alu", 32'(alu_control), 32'h2);
      chk("after_hcf_rd", 32'(rd), 3);
      tick();

      // ADDI x5,x0,0x7FF on both instances
      instr      = 32'h7FF00293;
      in_valid   = 1'b1;
      in_valid_b = 1'b1;
      tick();
      in_valid   = 1'b0;
      in_valid_b = 1'b0;
      chk("addi_alu", 32'(alu_control), 32'h2);
      chk("addi_use_imm", 32'(use_imm), 1);
      chk("addi_imm", 32'(imm), 32'h7FF);
      chk("addi_rd", 32'(rd), 5);
      chk("addi_regwrite", 32'(regwrite), 1);
      chk("b_addi_valid", 32'(out_valid_b), 1);
      chk("b_addi_regwrite", 32'(regwrite_b), 0);
      chk("b_addi_illegal", 32'(illegal_b), 0);
      chk("b_addi_alu", 32'(alu_control_b), 0);
      chk("b_addi_use_imm", 32'(use_imm_b), 0);
      tick();

      // Illegal R-type (f7=0x20)
      instr    = 32'h402081B3;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("ill_r_illegal", 32'(illegal), 1);
      chk("ill_r_regwrite", 32'(regwrite), 0);
      chk("ill_r_alu", 32'(alu_control), 32'hF);
      tick();

      // Illegal I-type shift (f3=5, f7=0x20)
      instr    = 32'h40105293;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("ill_i_illegal", 32'(illegal), 1);
      chk("ill_i_alu", 32'(alu_control), 32'hF);
      tick();

      // Backpressure: ADD held while OR waits
      out_ready = 1'b0;
      instr     = 32'h002081B3;
      in_valid  = 1'b1;
      tick();
      instr = 32'h0020E1B3;
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(out_valid), 1);
         chk("bp_alu", 32'(alu_control), 32'h2);
         chk("bp_in_ready", 32'(in_ready), 0);
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      chk("bp_replace_valid", 32'(out_valid), 1);
      chk("bp_replace_alu", 32'(alu_control), 32'h1);
      tick();
      chk("bp_drain", 32'(out_valid), 0);

      // Reset in the middle of a MUL stall
      instr    = 32'h0020A1B3;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("mw_in_ready", 32'(in_ready), 0);
      rst_n = 1'b0;
      tick();
      chk("mw_rst_valid", 32'(out_valid), 0);
      chk("mw_rst_in_ready", 32'(in_ready), 0);
      rst_n = 1'b1;
      #1;
      chk("mw_run_ready", 32'(in_ready), 1);
      tick();
      tick();
      tick();
      chk("mw_discarded", 32'(out_valid), 0);
      chk("mw_alu_zero", 32'(alu_control), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
